rd_resp_2reg: RTL and testbench

RD_RESP_2REG -- requirements
Module: rd_resp_2reg

---
 rtl/rd_resp_pkg.sv | 38 +++
 rtl/rd_resp_2reg_rx_fifo.sv | 74 +++++++
 rtl/rd_resp_2reg.sv | 120 ++++++++++++
 tb/tb_rd_resp_2reg.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rd_resp_pkg.sv
// Shared definitions for the receive-buffer read/response block:
// status word bit positions, register select encodings and a helper
// that packs the status word from its individual fields.
package rd_resp_pkg;

  // Status word bit positions
  localparam int NOT_EMPTY = 0;
  localparam int FULL      = 1;
  localparam int OVERRUN   = 2;
  localparam int UNDERFLOW = 3;
  localparam int COUNT_LSB = 4;
  localparam int COUNT_W   = 4;

  // Register select encodings
  typedef enum logic {
    SEL_STATUS = 1'b0,
    SEL_DATA   = 1'b1
  } reg_sel_e;

  // Assemble the 32-bit status word; unused bits are zero
  function automatic logic [31:0] packStatus(
    input logic               notEmpty,
    input logic               full,
    input logic               overrun,
    input logic               underflow,
    input logic [COUNT_W-1:0] count
  );
    logic [31:0] word;
    word                       = '0;
    word[NOT_EMPTY]            = notEmpty;
    word[FULL]                 = full;
    word[OVERRUN]              = overrun;
    word[UNDERFLOW]            = underflow;
    word[COUNT_LSB +: COUNT_W] = count;
    return word;
  endfunction

endpackage

// File: rtl/rd_resp_2reg_rx_fifo.sv
// Receive buffer storage: a circular FIFO with power-of-two depth.
// Requests are guarded internally, so a push into a full buffer is only
// taken when a pop happens on the same edge, and a pop of an empty
// buffer is ignored. The head entry is presented combinationally.
module rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic [DATA_W-1:0]       data_i,
  input  logic                    pop_i,
  output logic [DATA_W-1:0]       data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;

  logic w_full;
  logic w_empty;
  logic w_doPush;
  logic w_doPop;

  // Qualify push/pop against the current fill level
  always_comb begin
    w_full   = (r_count == CNT_W'(DEPTH));
    w_empty  = (r_count == '0);
    w_doPop  = pop_i && !w_empty;
    w_doPush = push_i && (!w_full || w_doPop);
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array is not reset; only the pointers define validity
  always_ff @(posedge clk_i) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= data_i;
    end
  end

  assign data_o  = r_mem[r_rdPtr];
  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign count_o = r_count;

endmodule

// File: rtl/rd_resp_2reg.sv
// Two-register read port in front of a receive buffer. A read strobe
// selects either the status word or the data register; the response
// comes back one cycle later with a single-cycle valid pulse, and the
// returned value is held until the next response. Data reads pop the
// buffer head; status reads return and clear the sticky error flags.
module rd_resp_2reg
  import rd_resp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_i,
  input  logic              reg_sel_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  output logic [31:0]       rdata_o,
  output logic              rvalid_o,
  output logic              irq_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;

  logic              w_dataRd;
  logic              w_statusRd;
  logic              w_pop;
  logic              w_push;
  logic              w_setOverrun;
  logic              w_setUnderflow;
  logic [CNT_W-1:0]  w_countNext;
  logic [31:0]       w_statusWord;
  logic [31:0]       w_readWord;

  logic [31:0]       r_rdata;
  logic              r_rvalid;
  logic              r_irq;
  logic              r_overrun;
  logic              r_underflow;

  rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rxFifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (rx_data_i),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  // Decode the access, qualify push/pop and build the response word
  always_comb begin
    w_dataRd       = rd_i && (reg_sel_i == SEL_DATA);
    w_statusRd     = rd_i && (reg_sel_i == SEL_STATUS);
    w_pop          = w_dataRd && !w_empty;
    w_push         = rx_valid_i && (!w_full || w_pop);
    w_setOverrun   = rx_valid_i && w_full && !w_pop;
    w_setUnderflow = w_dataRd && w_empty;
    w_countNext    = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
    w_statusWord   = packStatus(!w_empty, w_full, r_overrun, r_underflow,
                                COUNT_W'(w_count));
    w_readWord     = '0;
    if (w_statusRd) begin
      w_readWord = w_statusWord;
    end else if (w_pop) begin
      w_readWord = 32'(w_head);
    end
  end

  // Response register: one valid pulse per read, data held between reads
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= rd_i;
      if (rd_i) begin
        r_rdata <= w_readWord;
      end
    end
  end

  // Sticky error flags: a status read clears them, but a new event wins
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_overrun   <= 1'b0;
      r_underflow <= 1'b0;
    end else if (w_statusRd) begin
      r_overrun   <= w_setOverrun;
      r_underflow <= w_setUnderflow;
    end else begin
      r_overrun   <= r_overrun | w_setOverrun;
      r_underflow <= r_underflow | w_setUnderflow;
    end
  end

  // Interrupt reflects the fill level after this edge's push/pop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (w_countNext != '0);
    end
  end

  assign rdata_o  = r_rdata;
  assign rvalid_o = r_rvalid;
  assign irq_o    = r_irq;

endmodule

// File: tb/tb_rd_resp_2reg.sv
// Bench for rd_resp_2reg: directed scenarios followed by a random run,
// all checked against a queue-based model of the receive buffer.
module tb_rd_resp_2reg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              rd_i;
  logic              reg_sel_i;
  logic [DATA_W-1:0] rx_data_i;
  logic              rx_valid_i;
  logic [31:0]       rdata_o;
  logic              rvalid_o;
  logic              irq_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]  mdlQ[$];
  logic        mdlOvr;
  logic        mdlUdf;
  logic [31:0] expRdata;
  logic        expRvalid;
  logic        expIrq;

  rd_resp_2reg #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_i       (rd_i),
    .reg_sel_i  (reg_sel_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rdata_o    (rdata_o),
    .rvalid_o   (rvalid_o),
    .irq_o      (irq_o)
  );

  // Free-running clock
  always #5 clk_i = ~clk_i;

  // Status word from the model: count*16 + udf*8 + ovr*4 + full*2 + notEmpty
  function automatic logic [31:0] mdlStatus();
    int n;
    n = mdlQ.size();
    return 32'(n * 16 + (mdlUdf ? 8 : 0) + (mdlOvr ? 4 : 0) +
               (n == DEPTH ? 2 : 0) + (n != 0 ? 1 : 0));
  endfunction

  task automatic resetModel();
    mdlQ.delete();
    mdlOvr    = 1'b0;
    mdlUdf    = 1'b0;
    expRdata  = '0;
    expRvalid = 1'b0;
    expIrq    = 1'b0;
  endtask

  // Advance the model by one clock edge with the given inputs
  task automatic modelStep(input logic rd, input logic sel, input logic valid,
                           input logic [7:0] data);
    logic isData, isStatus, doPop, setOvr, setUdf;
    int   n;
    n        = mdlQ.size();
    isData   = rd && sel;
    isStatus = rd && !sel;
    doPop    = isData && (n > 0);
    setOvr   = valid && (n == DEPTH) && !doPop;
    setUdf   = isData && (n == 0);
    expRvalid = rd;
    if (isStatus) expRdata = mdlStatus();
    else if (isData) expRdata = (n > 0) ? 32'(mdlQ[0]) : 32'h0;
    if (doPop) void'(mdlQ.pop_front());
    if (valid && !setOvr) mdlQ.push_back(data);
    if (isStatus) begin
      mdlOvr = setOvr;
      mdlUdf = setUdf;
    end else begin
      mdlOvr = mdlOvr | setOvr;
      mdlUdf = mdlUdf | setUdf;
    end
    expIrq = (mdlQ.size() != 0);
  endtask

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, "_rvalid"}, 32'(rvalid_o), 32'(expRvalid));
    checkValue({tag, "_rdata"}, rdata_o, expRdata);
    checkValue({tag, "_irq"}, 32'(irq_o), 32'(expIrq));
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare to the model
  task automatic applyStimulus(input string tag, input logic rd, input logic sel,
                               input logic valid, input logic [7:0] data);
    @(negedge clk_i);
    rd_i       = rd;
    reg_sel_i  = sel;
    rx_valid_i = valid;
    rx_data_i  = data;
    @(posedge clk_i);
    #1;
    modelStep(rd, sel, valid, data);
    checkOutput(tag);
    rd_i       = 1'b0;
    rx_valid_i = 1'b0;
  endtask

  // Directed scenarios then a random run
  initial begin
    rst_i      = 1'b1;
    rd_i       = 1'b0;
    reg_sel_i  = 1'b0;
    rx_data_i  = '0;
    rx_valid_i = 1'b0;
    resetModel();
    #1;
    checkOutput("reset");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Two pushes then two data reads
    applyStimulus("push_a5", 1'b0, 1'b0, 1'b1, 8'hA5);
    applyStimulus("push_3c", 1'b0, 1'b0, 1'b1, 8'h3C);
    applyStimulus("rd_a5", 1'b1, 1'b1, 1'b0, 8'h00);
    checkValue("rd_a5_const", rdata_o, 32'h0000_00A5);
    applyStimulus("rd_3c", 1'b1, 1'b1, 1'b0, 8'h00);
    checkValue("rd_3c_const", rdata_o, 32'h0000_003C);
    checkValue("irq_fall", 32'(irq_o), 32'h0);
    applyStimulus("idle_hold", 1'b0, 1'b0, 1'b0, 8'h00);
    checkValue("hold_3c", rdata_o, 32'h0000_003C);

    // Underflow on empty buffer, then report and clear
    applyStimulus("rd_empty", 1'b1, 1'b1, 1'b0, 8'h00);
    checkValue("rd_empty_const", rdata_o, 32'h0);
    applyStimulus("st_udf", 1'b1, 1'b0, 1'b0, 8'h00);
    checkValue("st_udf_const", rdata_o, 32'h0000_0008);
    applyStimulus("st_clear", 1'b1, 1'b0, 1'b0, 8'h00);
    checkValue("st_clear_const", rdata_o, 32'h0);

    // Push and data read on empty buffer at the same edge
    applyStimulus("rd_push_empty", 1'b1, 1'b1, 1'b1, 8'h99);
    checkValue("rd_push_empty_const", rdata_o, 32'h0);
    applyStimulus("st_udf_push", 1'b1, 1'b0, 1'b0, 8'h00);
    checkValue("st_udf_push_const", rdata_o, 32'h0000_0019);
    applyStimulus("rd_99", 1'b1, 1'b1, 1'b0, 8'h00);
    checkValue("rd_99_const", rdata_o, 32'h0000_0099);

    // Overfill by one byte
    for (int i = 1; i <= 5; i++) begin
      applyStimulus("fill", 1'b0, 1'b0, 1'b1, 8'(i));
    end
    applyStimulus("st_ovr", 1'b1, 1'b0, 1'b0, 8'h00);
    checkValue("st_ovr_const", rdata_o, 32'h0000_0047);
    applyStimulus("st_ovr_clr", 1'b1, 1'b0, 1'b0, 8'h00);
    checkValue("st_ovr_clr_const", rdata_o, 32'h0000_0043);

    // Push and pop together while full
    applyStimulus("full_pushpop", 1'b1, 1'b1, 1'b1, 8'h77);
    checkValue("full_pushpop_const", rdata_o, 32'h0000_0001);
    applyStimulus("st_full", 1'b1, 1'b0, 1'b0, 8'h00);
    checkValue("st_full_const", rdata_o, 32'h0000_0043);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("drain", 1'b1, 1'b1, 1'b0, 8'h00);
    end
    checkValue("last_77", rdata_o, 32'h0000_0077);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 8'($urandom));
    end

    // Reset right after a data read
    applyStimulus("pre_rst_push1", 1'b0, 1'b0, 1'b1, 8'h11);
    applyStimulus("pre_rst_push2", 1'b0, 1'b0, 1'b1, 8'h22);
    applyStimulus("pre_rst_rd", 1'b1, 1'b1, 1'b0, 8'h00);
    #3;
    rst_i = 1'b1;
    #1;
    resetModel();
    checkOutput("async_rst");
    @(negedge clk_i);
    rd_i      = 1'b1;
    reg_sel_i = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("in_rst");
    @(negedge clk_i);
    rst_i = 1'b0;
    rd_i  = 1'b0;
    applyStimulus("post_rst_idle", 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus("post_rst_st", 1'b1, 1'b0, 1'b0, 8'h00);
    checkValue("post_rst_st_const", rdata_o, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
